decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Instruction decode stage directly upstream of the 8x16 register file.
//  Accepts one 16-bit instruction per cycle over valid/ready and splits it into opcode, rD/rA/rB selects, immediate and a write flag.
//  Drives the register file's rA/rB read selects and the destination select/write that travel with the instruction.
//  Stalls issue while a source or destination register has an outstanding write (scoreboard).
// PARAMETERS
//  NUM_REGS   8    register count; selects are $clog2(NUM_REGS)=3 bits
//  DATA_W     16   instruction and immediate width
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst          in   1   synchronous, active-high reset
//  in_valid     in   1   instruction offered
//  in_ready     out  1   stage accepts in_instr this cycle
//  in_instr     in   16  [15:12] opcode, [11:9] rD, [8] hi, [7:5] rA, [4:2] rB, [7:0] imm8
//  out_valid    out  1   decoded instruction held in output register
//  out_ready    in   1   downstream consumes output this cycle
//  out_opcode   out  4   registered opcode
//  rD_select    out  3   destination register
//  rA_select    out  3   source A register (to register file)
//  rB_select    out  3   source B register (to register file)
//  out_imm      out  16  hi=0: {8'h00,imm8}; hi=1: {imm8,8'h00}
//  rD_write     out  1   instruction writes rD
//  wb_valid     in   1   writeback of a register completes this cycle
//  wb_select    in   3   register being written back
// BEHAVIOUR
//  - Reset: out_valid=0, all output fields 0, rD_write=0, pending mask=8'h00; in_ready=1 the cycle after reset.
//  - Opcode table: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,6 SHL,7 SHR: write rD, use rA,rB; 5 NOT: write, rA only;
//    8 LDI: write, no sources; 9 CMP: no write, rA,rB; A LD: write, rA; B ST: no write, rA,rB; C BR: no write, rB;
//    D-F: NOP, no write, no sources.
//  - hazard = in_valid & (pending[rA]&useA | pending[rB]&useB | pending[rD]&write); unused fields never stall.
//  - in_ready = (!out_valid | out_ready) & !hazard; purely combinational, no ready-to-valid path besides this.
//  - Accept (in_valid & in_ready): output register loads decoded fields next edge, out_valid=1; latency 1 cycle.
//  - out_valid & out_ready & no accept: out_valid=0 next edge; fields hold last value.
//  - out_valid & !out_ready: all outputs held stable (no change while stalled downstream).
//  - Scoreboard: accept with write sets pending[rD]; wb_valid clears pending[wb_select].
//    Same-cycle set and clear of same register: set wins (bit=1).
//    No bypass: a clear is visible to the hazard check one cycle later.
//  - wb_valid to a non-pending register: no effect.
//  - Reset mid-operation: in-flight output dropped, pending mask cleared; no partial state survives.
// CONFIGURATION
//  DECODE_SCOREBOARD_EN defined: scoreboard and hazard stall as above.
//  Undefined: hazard=0 always, pending mask not built, wb_valid/wb_select ignored;
//    in_ready = !out_valid | out_ready.
// STRUCTURE
//  cpu_pkg: opcode constants, instruction field bit positions, REG_SEL_W=3, use/write lookup function.
//  Sub-module hazard_scoreboard: pending mask, set/clear, hazard output; instanced only under DECODE_SCOREBOARD_EN.
// TESTING
//  1 Reset, then in_instr=16'h024C (ADD r1,r2,r3), out_ready=1 -> next cycle out_valid=1, op=0, rD=1, rA=2, rB=3, rD_write=1.
//  2 16'h88A5 (LDI r4,0xA5) then 16'h0A90 (ADD r5,r4,r4) -> in_ready=0 until cycle after wb_valid=1,wb_select=4; then accepted.
//  3 16'h89A5 (LDI r4 hi=1) -> out_imm=16'hA500, rA/rB never cause stall though fields nonzero.
//  4 out_ready=0 with out_valid=1 -> in_ready=0, outputs unchanged 5 cycles; release -> next instruction loads same edge.
//  5 wb_valid for r4 same cycle new write to r4 accepted -> pending[4]=1 afterwards; next reader of r4 stalls.
//  6 rst asserted while r4 pending and out_valid=1 -> out_valid=0, pending=0; ADD reading r4 accepted immediately.
//  Run 1-6 with and without DECODE_SCOREBOARD_EN; without it scenario 2 issues back-to-back.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-select width, instruction field layout, opcodes
// and the per-opcode register usage lookup used by the decode stage.
package cpu_pkg;

  localparam int NUM_REGS  = 8;
  localparam int DATA_W    = 16;
  localparam int REG_SEL_W = $clog2(NUM_REGS);

  localparam int OPC_W   = 4;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int HI_BIT  = 8;
  localparam int RA_LSB  = 5;
  localparam int RB_LSB  = 2;
  localparam int IMM_W   = 8;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_LDI = 4'h8,
    OP_CMP = 4'h9,
    OP_LD  = 4'hA,
    OP_ST  = 4'hB,
    OP_BR  = 4'hC
  } opcode_e;

  typedef struct packed {
    logic use_a;
    logic use_b;
    logic write;
  } reg_use_t;

  // Opcodes 0xD-0xF are NOPs: no sources, no destination write.
  function automatic reg_use_t reg_use(input logic [OPC_W-1:0] opcode);
    reg_use_t u;
    u = '0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
        u.use_a = 1'b1;
        u.use_b = 1'b1;
        u.write = 1'b1;
      end
      OP_NOT, OP_LD: begin
        u.use_a = 1'b1;
        u.write = 1'b1;
      end
      OP_LDI: u.write = 1'b1;
      OP_CMP, OP_ST: begin
        u.use_a = 1'b1;
        u.use_b = 1'b1;
      end
      OP_BR:   u.use_b = 1'b1;
      default: u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue of a writing
// instruction, cleared on writeback; flags a hazard for the offered instruction.
module hazard_scoreboard
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [REG_SEL_W-1:0] rd,
  input  logic [REG_SEL_W-1:0] ra,
  input  logic [REG_SEL_W-1:0] rb,
  input  logic                 use_a,
  input  logic                 use_b,
  input  logic                 write,
  input  logic                 set_en,
  input  logic                 wb_valid,
  input  logic [REG_SEL_W-1:0] wb_select,
  output logic                 hazard
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en)   set_mask[rd]        = 1'b1;
    if (wb_valid) clr_mask[wb_select] = 1'b1;
  end

  // NOTE: state uses non-blocking assignments; clear then set so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_mask) | set_mask;
  end

  // Hazard looks at the registered mask only, so a writeback unblocks one cycle later.
  assign hazard = in_valid & ((pending[ra] & use_a) |
                              (pending[rb] & use_b) |
                              (pending[rd] & write));

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage feeding the 8x16 register file over valid/ready.
// Define DECODE_SCOREBOARD_EN to build the pending-write scoreboard and hazard stall.
module decode_stage
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OPC_W-1:0]     out_opcode,
  output logic [REG_SEL_W-1:0] rD_select,
  output logic [REG_SEL_W-1:0] rA_select,
  output logic [REG_SEL_W-1:0] rB_select,
  output logic [DATA_W-1:0]    out_imm,
  output logic                 rD_write,
  input  logic                 wb_valid,
  input  logic [REG_SEL_W-1:0] wb_select
);

  logic [OPC_W-1:0]     dec_opcode;
  logic [REG_SEL_W-1:0] dec_rd;
  logic [REG_SEL_W-1:0] dec_ra;
  logic [REG_SEL_W-1:0] dec_rb;
  logic [IMM_W-1:0]     dec_imm8;
  logic [DATA_W-1:0]    dec_imm;
  reg_use_t             dec_use;
  logic                 hazard;
  logic                 accept;

  assign dec_opcode = in_instr[OPC_LSB +: OPC_W];
  assign dec_rd     = in_instr[RD_LSB +: REG_SEL_W];
  assign dec_ra     = in_instr[RA_LSB +: REG_SEL_W];
  assign dec_rb     = in_instr[RB_LSB +: REG_SEL_W];
  assign dec_imm8   = in_instr[IMM_W-1:0];
  assign dec_imm    = in_instr[HI_BIT] ? {dec_imm8, {IMM_W{1'b0}}}
                                       : {{IMM_W{1'b0}}, dec_imm8};
  assign dec_use    = reg_use(dec_opcode);

`ifdef DECODE_SCOREBOARD_EN
  hazard_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .rd        (dec_rd),
    .ra        (dec_ra),
    .rb        (dec_rb),
    .use_a     (dec_use.use_a),
    .use_b     (dec_use.use_b),
    .write     (dec_use.write),
    .set_en    (accept & dec_use.write),
    .wb_valid  (wb_valid),
    .wb_select (wb_select),
    .hazard    (hazard)
  );
`else
  logic unused_inputs;
  assign unused_inputs = ^{wb_valid, wb_select, dec_use.use_a, dec_use.use_b};
  assign hazard        = 1'b0;
`endif

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // NOTE: fields are reset too, so no value from before reset is ever visible downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_opcode <= '0;
      rD_select  <= '0;
      rA_select  <= '0;
      rB_select  <= '0;
      out_imm    <= '0;
      rD_write   <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_opcode <= dec_opcode;
      rD_select  <= dec_rd;
      rA_select  <= dec_ra;
      rB_select  <= dec_rb;
      out_imm    <= dec_imm;
      rD_write   <= dec_use.write;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the decode/scoreboard rules.
module tb_decode_stage;

`ifdef DECODE_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [2:0]  rD_select;
  logic [2:0]  rA_select;
  logic [2:0]  rB_select;
  logic [15:0] out_imm;
  logic        rD_write;
  logic        wb_valid;
  logic [2:0]  wb_select;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .rD_select  (rD_select),
    .rA_select  (rA_select),
    .rB_select  (rB_select),
    .out_imm    (out_imm),
    .rD_write   (rD_write),
    .wb_valid   (wb_valid),
    .wb_select  (wb_select)
  );

  // Reference model state
  bit        m_valid;
  bit        m_wr;
  bit [3:0]  m_op;
  bit [2:0]  m_rd;
  bit [2:0]  m_ra;
  bit [2:0]  m_rb;
  bit [15:0] m_imm;
  bit        pend [8];
  bit        seen_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_use(input bit [3:0] op, output bit ua, output bit ub, output bit wr);
    ua = 1'b0; ub = 1'b0; wr = 1'b0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7: begin ua = 1'b1; ub = 1'b1; wr = 1'b1; end
      4'h5, 4'hA: begin ua = 1'b1; wr = 1'b1; end
      4'h8:       wr = 1'b1;
      4'h9, 4'hB: begin ua = 1'b1; ub = 1'b1; end
      4'hC:       ub = 1'b1;
      default:    ;
    endcase
  endfunction

  function automatic bit ref_ready(input bit v, input bit [15:0] ins, input bit ordy);
    bit ua, ub, wr, conflict;
    ref_use(ins[15:12], ua, ub, wr);
    conflict = (ua && pend[ins[7:5]]) || (ub && pend[ins[4:2]]) || (wr && pend[ins[11:9]]);
    return (!m_valid || ordy) && !(SB_EN && v && conflict);
  endfunction

  task automatic check_outputs();
    check("out_valid",  out_valid,  m_valid);
    check("out_opcode", out_opcode, m_op);
    check("rD_select",  rD_select,  m_rd);
    check("rA_select",  rA_select,  m_ra);
    check("rB_select",  rB_select,  m_rb);
    check("out_imm",    out_imm,    m_imm);
    check("rD_write",   rD_write,   m_wr);
  endtask

  // One clock: drive at negedge, check in_ready, update model at posedge, check outputs.
  task automatic cycle(input bit r, input bit v, input bit [15:0] ins, input bit ordy,
                       input bit wbv, input bit [2:0] wbs);
    bit er, acc, ua, ub, wr;
    rst = r; in_valid = v; in_instr = ins; out_ready = ordy; wb_valid = wbv; wb_select = wbs;
    #1;
    er = ref_ready(v, ins, ordy);
    seen_ready = in_ready;
    if (!r) check("in_ready", in_ready, er);
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_wr = 1'b0; m_op = '0; m_rd = '0; m_ra = '0; m_rb = '0; m_imm = '0;
      for (int i = 0; i < 8; i++) pend[i] = 1'b0;
    end else begin
      acc = v && er;
      ref_use(ins[15:12], ua, ub, wr);
      if (SB_EN && wbv) pend[wbs] = 1'b0;
      if (SB_EN && acc && wr) pend[ins[11:9]] = 1'b1;
      if (acc) begin
        m_valid = 1'b1;
        m_op    = ins[15:12];
        m_rd    = ins[11:9];
        m_ra    = ins[7:5];
        m_rb    = ins[4:2];
        m_imm   = ins[8] ? {ins[7:0], 8'h00} : {8'h00, ins[7:0]};
        m_wr    = wr;
      end else if (ordy) begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0; wb_valid = 1'b0; wb_select = '0;
    @(negedge clk);
    do_reset();
    do_reset();

    // Reset state
    cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0);
    check("rst_in_ready", seen_ready, 1);
    check("rst_out_valid", out_valid, 0);

    // 1: ADD r1,r2,r3 with one-cycle latency
    cycle(1'b0, 1'b1, 16'h024C, 1'b1, 1'b0, 3'd0);
    check("s1_valid", out_valid, 1);
    check("s1_op", out_opcode, 4'h0);
    check("s1_rd", rD_select, 3'd1);
    check("s1_ra", rA_select, 3'd2);
    check("s1_rb", rB_select, 3'd3);
    check("s1_wr", rD_write, 1);

    // 2: LDI r4 then ADD r5,r4,r4 stalls until the cycle after writeback of r4
    do_reset();
    cycle(1'b0, 1'b1, 16'h88A5, 1'b1, 1'b0, 3'd0);
    cycle(1'b0, 1'b1, 16'h0A90, 1'b1, 1'b0, 3'd0);
    check("s2_first_offer", seen_ready, SB_EN ? 0 : 1);
    cycle(1'b0, 1'b1, 16'h0A90, 1'b1, 1'b0, 3'd0);
    cycle(1'b0, 1'b1, 16'h0A90, 1'b1, 1'b1, 3'd4);
    check("s2_wb_cycle", seen_ready, SB_EN ? 0 : 1);
    cycle(1'b0, 1'b1, 16'h0A90, 1'b1, 1'b0, 3'd0);
    check("s2_after_wb", seen_ready, 1);
    check("s2_rd", rD_select, 3'd5);

    // 3: hi immediate; nonzero but unused rA/rB fields point at pending registers
    do_reset();
    cycle(1'b0, 1'b1, 16'h8A00, 1'b1, 1'b0, 3'd0);
    cycle(1'b0, 1'b1, 16'h8200, 1'b1, 1'b0, 3'd0);
    cycle(1'b0, 1'b1, 16'h89A5, 1'b1, 1'b0, 3'd0);
    check("s3_no_stall", seen_ready, 1);
    check("s3_imm", out_imm, 16'hA500);

    // 4: downstream stall holds outputs for 5 cycles, then the waiting instruction loads
    do_reset();
    cycle(1'b0, 1'b1, 16'h024C, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 16'hC0F8, 1'b0, 1'b0, 3'd0);
      check("s4_blocked", seen_ready, 0);
      check("s4_hold_op", out_opcode, 4'h0);
      check("s4_hold_imm", out_imm, 16'h004C);
    end
    cycle(1'b0, 1'b1, 16'hC0F8, 1'b1, 1'b0, 3'd0);
    check("s4_release", seen_ready, 1);
    check("s4_new_op", out_opcode, 4'hC);

    // 5: writeback of non-pending r4 in the same cycle LDI r4 issues: set wins
    do_reset();
    cycle(1'b0, 1'b1, 16'h88A5, 1'b1, 1'b1, 3'd4);
    check("s5_accept", seen_ready, 1);
    cycle(1'b0, 1'b1, 16'h0A90, 1'b1, 1'b0, 3'd0);
    check("s5_reader", seen_ready, SB_EN ? 0 : 1);

    // 6: reset while r4 pending and output held
    do_reset();
    cycle(1'b0, 1'b1, 16'h88A5, 1'b0, 1'b0, 3'd0);
    check("s6_held", out_valid, 1);
    do_reset();
    check("s6_dropped", out_valid, 0);
    cycle(1'b0, 1'b1, 16'h0A90, 1'b1, 1'b0, 3'd0);
    check("s6_accept", seen_ready, 1);
    check("s6_rd", rD_select, 3'd5);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom % 300) == 0, ($urandom % 4) != 0, 16'($urandom), ($urandom % 4) != 0,
            ($urandom % 3) == 0, 3'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
